// File: rtl/pc_fold_acc_pkg.sv
// pc_pkg: shared types, mode encodings and width helpers for the segmented
// popcount accumulator (pc_fold_acc) and its sub-blocks.
package pc_pkg;

  // Top-level control FSM: ACC accepts segments, HOLD presents a result.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Result interpretation, sampled with segment 0.
  localparam logic MODE_UNSIGNED = 1'b0;  // plain popcount
  localparam logic MODE_BIPOLAR  = 1'b1;  // 2*pc - N

  // Bits needed to hold a count in 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return int'($clog2(n + 1));
  endfunction

endpackage

// File: rtl/pc_fold_acc_if.sv
// pc_fold_acc_if: segment input handshake and result output handshake.
//   in_valid/in_ready/in_bits/mode : one CH x SEG_W segment per transfer
//   out_valid/out_ready/out_sum    : CH signed results of width OUT_W
// master = producer/consumer side, slave = pc_fold_acc.
interface pc_fold_acc_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned SEG_W = 8,
  parameter int unsigned NSEG  = 4
) ();
  localparam int unsigned OUT_W = pc_pkg::cnt_w(SEG_W * NSEG) + 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [CH-1:0][SEG_W-1:0]   in_bits;
  logic                       mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [CH-1:0][OUT_W-1:0]   out_sum;

  modport master (
    output in_valid, in_bits, mode, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_bits, mode, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/pc_fold_acc_seg_popcount.sv
// seg_popcount: combinational population count of one SEG_W-bit segment.
//   bits  : segment bits
//   cnt_c : number of ones, width clog2(SEG_W+1)
module seg_popcount
  import pc_pkg::*;
#(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0]          bits,
  output logic [cnt_w(SEG_W)-1:0]   cnt_c
);
  localparam int unsigned PC_W = cnt_w(SEG_W);

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(SEG_W); i++) begin
      cnt_c = cnt_c + PC_W'(bits[i]);
    end
  end
endmodule

// File: rtl/pc_fold_acc.sv
// pc_fold_acc: folds NSEG segments of CH x SEG_W XNOR bits into per-channel
// popcounts, optionally mapped to bipolar (2*pc - N). Two stages: S1 registers
// segment popcounts, S2 accumulates; the result is held until consumed.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pc_fold_acc_if (segment in, result out)
module pc_fold_acc
  import pc_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned SEG_W = 8,
  parameter int unsigned NSEG  = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_fold_acc_if.slave  bus
);
  localparam int unsigned N     = SEG_W * NSEG;
  localparam int unsigned ACC_W = cnt_w(N);
  localparam int unsigned OUT_W = ACC_W + 1;
  localparam int unsigned PC_W  = cnt_w(SEG_W);
  localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  state_t                   state_q, state_d;
  logic                     pend_q, pend_d;       // last segment in flight
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [CNT_W-1:0]         seg_cnt;
  logic                     mode_q;
  logic                     s1_valid, s1_first, s1_last;
  logic [CH-1:0][PC_W-1:0]  s1_pc;
  logic [CH-1:0][PC_W-1:0]  pc_c;
  logic [CH-1:0][ACC_W-1:0] acc;
  logic [CH-1:0][ACC_W-1:0] acc_c;
  logic [CH-1:0][OUT_W-1:0] out_sum_q;
  logic [CH-1:0][OUT_W-1:0] res_c;
  logic                     accept_c;
  logic                     seg_last_c;
  logic                     absorb_last_c;

  assign accept_c      = bus.in_valid && in_ready_q;
  assign seg_last_c    = (seg_cnt == CNT_W'(NSEG - 1));
  assign absorb_last_c = s1_valid && s1_last;

  for (genvar c = 0; c < int'(CH); c++) begin : g_ch
    seg_popcount #(.SEG_W(SEG_W)) u_pc (
      .bits  (bus.in_bits[c]),
      .cnt_c (pc_c[c])
    );
  end

  // S2 accumulate (segment 0 loads) and result mapping.
  always_comb begin
    acc_c = '0;
    res_c = '0;
    for (int c = 0; c < int'(CH); c++) begin
      acc_c[c] = s1_first ? ACC_W'(s1_pc[c]) : acc[c] + ACC_W'(s1_pc[c]);
      if (mode_q == MODE_BIPOLAR) begin
        res_c[c] = {acc_c[c], 1'b0} - OUT_W'(N);
      end else begin
        res_c[c] = OUT_W'(acc_c[c]);
      end
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      pend_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state: ACC until S2 absorbs the last segment, HOLD until consumed.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_ACC: begin
        if (accept_c && seg_last_c) pend_d = 1'b1;
        if (absorb_last_c) begin
          state_d = ST_HOLD;
          pend_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
    in_ready_d  = (state_d == ST_ACC) && !pend_d;
    out_valid_d = (state_d == ST_HOLD);
  end

  // Datapath: segment counter, S1 stage, accumulator, held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_cnt   <= '0;
      mode_q    <= MODE_UNSIGNED;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_pc     <= '0;
      acc       <= '0;
      out_sum_q <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        seg_cnt  <= seg_last_c ? '0 : seg_cnt + CNT_W'(1);
        s1_pc    <= pc_c;
        s1_first <= (seg_cnt == '0);
        s1_last  <= seg_last_c;
        if (seg_cnt == '0) mode_q <= bus.mode;
      end
      if (s1_valid) acc <= acc_c;
      if (absorb_last_c) out_sum_q <= res_c;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
endmodule

// File: doc/pc_fold_acc.md
PC_FOLD_ACC -- requirements
Module: pc_fold_acc

Interface
REQ-001 SHALL have parameter CH, default 4: output channels processed in parallel.
REQ-002 SHALL have parameter SEG_W, default 8: input bits per channel per segment.
REQ-003 SHALL have parameter NSEG, default 4: segments per vector; total length N = SEG_W*NSEG.
REQ-004 SHALL derive ACC_W = clog2(N+1) and OUT_W = ACC_W+1 (signed result width).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 in_valid  input  1  segment present on in_bits.
REQ-008 in_ready  output  1  block accepts a segment this cycle.
REQ-009 in_bits  input  CH x SEG_W  per-channel product bits (XNOR results) for one segment.
REQ-010 mode  input  1  0 = unsigned popcount, 1 = bipolar result (2*pc - N); sampled with segment 0.
REQ-011 out_valid  output  1  result vector valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_sum  output  CH x OUT_W  per-channel result, two's complement.

Function
REQ-014 SHALL accept a segment when in_valid && in_ready; segments of a vector are accepted in order 0..NSEG-1, counted by seg_cnt.
REQ-015 SHALL use two pipeline stages: S1 registers per-channel segment popcount (width clog2(SEG_W+1)) plus a last flag; S2 adds S1 into per-channel accumulator acc (width ACC_W).
REQ-016 S2 SHALL load acc with the S1 value (not add) when the S1 segment is segment 0.
REQ-017 FSM states: ACC (accepting) and HOLD (result pending); reset state ACC.
REQ-018 ACC -> HOLD SHALL occur on the edge where S2 absorbs the last segment; HOLD -> ACC on out_valid && out_ready.
REQ-019 in_ready SHALL be 1 in ACC except from the cycle after the last segment is accepted until HOLD exits; in_ready SHALL be 0 throughout HOLD.
REQ-020 out_valid SHALL equal (state == HOLD); out_sum and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-021 Latency: last segment accepted in cycle t -> out_valid first high in cycle t+2.
REQ-022 In HOLD with out_ready=1, in_ready SHALL rise the following cycle (no same-cycle bypass).
REQ-023 seg_cnt SHALL wrap NSEG-1 -> 0 after the last segment; NSEG=1 SHALL make every segment the last one.
REQ-024 mode SHALL be latched at segment-0 acceptance; changes on later segments SHALL be ignored.
REQ-025 out_sum SHALL be zero-extended acc for mode 0, 2*acc - N (signed OUT_W) for mode 1; no overflow is possible at these widths.
REQ-026 in_valid=0 cycles between segments SHALL not disturb acc or seg_cnt.

Reset
REQ-027 On rst=1 at a clock edge: state=ACC, seg_cnt=0, S1 valid=0, acc=0, latched mode=0, out_valid=0, out_sum=0; in_ready=1 the cycle after rst deasserts.
REQ-028 rst mid-vector or in HOLD SHALL discard partial/pending results; no out_valid for the aborted vector.

Structure
REQ-029 Package pc_pkg SHALL hold the state enum, mode encoding constants and a clog2-based width function for ACC_W/OUT_W.
REQ-030 One sub-module, seg_popcount (combinational, SEG_W bits -> clog2(SEG_W+1) count), SHALL be instantiated CH times.

Verification (CH=4, SEG_W=8, NSEG=4, N=32)
REQ-031 mode 0, all four segments 8'hFF on channel 0, 8'h00 elsewhere -> out_sum = {32,0,0,0}, out_valid in cycle t+2 after last accept.
REQ-032 mode 1, channel 1 all ones, channel 2 all zeros, channel 3 alternating 8'hAA -> out_sum ch1=+32, ch2=-32, ch3=0.
REQ-033 out_ready held 0 for 5 cycles in HOLD -> out_sum stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle, next vector unaffected by previous acc.
REQ-034 random in_valid gaps (50% duty) over 10 vectors -> results match a reference popcount model, order preserved.
REQ-035 rst asserted after segment 2 -> no out_valid; next full vector of 8'h0F segments in mode 0 -> out_sum = 16 per channel.
REQ-036 mode toggled 0 -> 1 after segment 0 -> result uses mode 0.
